// File: rtl/pc_int_ctrl.sv
// Program counter with a vectored interrupt front end: edge-latched requests,
// fixed-priority entry, a single-level return address and step-strobed updates.
module pc_int_ctrl #(
  parameter int unsigned      WIDTH       = 27,
  parameter int unsigned      NUM_INT     = 8,
  parameter logic [WIDTH-1:0] PC_START    = 27'hC01400,
  parameter logic [WIDTH-1:0] VECTOR_BASE = '0,
  parameter logic [WIDTH-1:0] ROM_BASE    = 27'hC01400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeBack,
  input  logic               jump,
  input  logic               offset,
  input  logic [WIDTH-1:0]   jump_addr,
  input  logic               reti,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_wdata,
  output logic [WIDTH-1:0]   pc_out,
  output logic [NUM_INT-1:0] int_ack,
  output logic [NUM_INT-1:0] int_pending,
  output logic               int_active
);

  logic [1:0]         rdy_q, rdy_d;
  logic               wb_prev_q;
  logic [NUM_INT-1:0] int_prev_q;
  logic [NUM_INT-1:0] pending_q, pending_d;
  logic [NUM_INT-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]   backup_q, backup_d;
  logic               active_q, active_d;
  logic [NUM_INT-1:0] ack_q, ack_d;

  logic               ready;
  logic               step;
  logic               do_reti;
  logic               take_int;
  logic               found;
  logic [NUM_INT-1:0] req;
  logic [NUM_INT-1:0] grant;
  logic [NUM_INT-1:0] rise;
  logic [WIDTH-1:0]   vec;
  logic [WIDTH-1:0]   seq_pc;

  // Reset release walks through two flops so steps and edges start on a clean clock.
  assign rdy_d    = {rdy_q[0], 1'b1};
  assign ready    = rdy_q[1];
  assign step     = ready & writeBack & ~wb_prev_q;
  assign rise     = ready ? (int_in & ~int_prev_q) : '0;
  assign req      = pending_q & mask_q;
  assign seq_pc   = jump ? (offset ? pc_q + jump_addr : jump_addr) : pc_q + WIDTH'(1);
  assign do_reti  = step & reti & active_q;
  assign take_int = step & ~do_reti & ~active_q & (pc_q < ROM_BASE) & (|req);

  always_comb begin
    grant = '0;
    vec   = VECTOR_BASE + WIDTH'(1);
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (req[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        vec      = VECTOR_BASE + WIDTH'(i) + WIDTH'(1);
      end
    end
  end

  always_comb begin
    pc_d      = pc_q;
    backup_d  = backup_q;
    active_d  = active_q;
    ack_d     = '0;
    pending_d = pending_q;
    if (do_reti) begin
      pc_d     = backup_q;
      active_d = 1'b0;
    end else if (take_int) begin
      pc_d      = vec;
      backup_d  = seq_pc;
      active_d  = 1'b1;
      ack_d     = grant;
      pending_d = pending_q & ~grant;
    end else if (step) begin
      pc_d = seq_pc;
    end
    // A fresh edge overrides the clear of the channel being serviced.
    pending_d = pending_d | rise;
    mask_d    = (ready && mask_we) ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q      <= '0;
      wb_prev_q  <= 1'b0;
      int_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      pc_q       <= PC_START;
      backup_q   <= '0;
      active_q   <= 1'b0;
      ack_q      <= '0;
    end else begin
      rdy_q      <= rdy_d;
      wb_prev_q  <= writeBack;
      int_prev_q <= int_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      pc_q       <= pc_d;
      backup_q   <= backup_d;
      active_q   <= active_d;
      ack_q      <= ack_d;
    end
  end

  assign pc_out      = pc_q;
  assign int_ack     = ack_q;
  assign int_pending = pending_q;
  assign int_active  = active_q;

endmodule

// File: tb/tb_pc_int_ctrl.sv
// Self-checking bench for pc_int_ctrl (WIDTH=27, NUM_INT=4): directed scenarios
// with fixed expectations plus a randomized run against a behavioural model.
module tb_pc_int_ctrl;

  logic        clk;
  logic        reset;
  logic        writeBack;
  logic        jump;
  logic        offset;
  logic [26:0] jump_addr;
  logic        reti;
  logic [3:0]  int_in;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [26:0] pc_out;
  logic [3:0]  int_ack;
  logic [3:0]  int_pending;
  logic        int_active;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] ack_seen;

  // Behavioural model state
  logic [26:0] m_pc, m_bk;
  logic        m_act, m_wbp;
  logic [3:0]  m_pend, m_mask, m_intp, m_ack;

  pc_int_ctrl #(.NUM_INT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .writeBack  (writeBack),
    .jump       (jump),
    .offset     (offset),
    .jump_addr  (jump_addr),
    .reti       (reti),
    .int_in     (int_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pc_out     (pc_out),
    .int_ack    (int_ack),
    .int_pending(int_pending),
    .int_active (int_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 27'hC01400; m_bk = '0; m_act = 1'b0; m_wbp = 1'b0;
    m_pend = '0; m_mask = 4'hF; m_intp = '0; m_ack = '0;
  endtask

  // Advance one clock; the model computes the next state from the inputs present at the edge.
  task automatic tick();
    logic [26:0] npc, nbk, target;
    logic        nact;
    logic [3:0]  npend, nack, want;
    bit          stepping;
    npc = m_pc; nbk = m_bk; nact = m_act; npend = m_pend; nack = '0;
    stepping = writeBack && !m_wbp;
    want = m_pend & m_mask;
    if (jump) target = offset ? m_pc + jump_addr : jump_addr;
    else      target = m_pc + 27'd1;
    if (stepping) begin
      if (reti && m_act) begin
        npc = m_bk; nact = 1'b0;
      end else if (!m_act && m_pc < 27'hC01400 && want != 0) begin
        for (int c = 3; c >= 0; c--) if (want[c]) begin
          npc = 27'(c + 1); nack = 4'(1 << c);
        end
        nbk = target; nact = 1'b1; npend = npend & ~nack;
      end else begin
        npc = target;
      end
    end
    npend = npend | (int_in & ~m_intp);
    @(posedge clk);
    m_pc = npc; m_bk = nbk; m_act = nact; m_pend = npend; m_ack = nack;
    if (mask_we) m_mask = mask_wdata;
    m_wbp = writeBack; m_intp = int_in;
    #1;
  endtask

  task automatic clear_inputs();
    writeBack = 0; jump = 0; offset = 0; jump_addr = '0; reti = 0;
    int_in = '0; mask_we = 0; mask_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #4;
    reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic step(input logic j, input logic o, input logic [26:0] a, input logic r);
    jump = j; offset = o; jump_addr = a; reti = r; writeBack = 1'b1;
    tick();
    ack_seen = int_ack;
    writeBack = 0; jump = 0; offset = 0; jump_addr = '0; reti = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc_out !== 27'hC01400) $display("FAIL reset_pc got %h want c01400", pc_out); else n_pass++;
    n_checks++; if (int_active !== 1'b0) $display("FAIL reset_active got %b want 0", int_active); else n_pass++;
    n_checks++; if (int_pending !== 4'b0000) $display("FAIL reset_pending got %b want 0000", int_pending); else n_pass++;
    n_checks++; if (int_ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", int_ack); else n_pass++;
  endtask

  task automatic test_rom_steps();
    logic [26:0] exp_pc;
    do_reset();
    exp_pc = 27'hC01400;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, 0);
      exp_pc = exp_pc + 27'd1;
      n_checks++; if (pc_out !== exp_pc) $display("FAIL rom_step%0d got %h want %h", k, pc_out, exp_pc); else n_pass++;
    end
    int_in = 4'b0001; tick(); int_in = '0;
    step(0, 0, '0, 0);
    n_checks++; if (pc_out !== 27'hC01404) $display("FAIL rom_no_entry_pc got %h want c01404", pc_out); else n_pass++;
    n_checks++; if (ack_seen !== 4'b0000) $display("FAIL rom_no_ack got %b want 0000", ack_seen); else n_pass++;
    n_checks++; if (int_pending !== 4'b0001) $display("FAIL rom_pending got %b want 0001", int_pending); else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    step(0, 0, 27'h100, 0); step(1, 0, 27'h100, 0);
    int_in = 4'b0110; tick(); int_in = '0; tick();
    step(0, 0, '0, 0);
    n_checks++; if (pc_out !== 27'h002) $display("FAIL prio_vec got %h want 002", pc_out); else n_pass++;
    n_checks++; if (ack_seen !== 4'b0010) $display("FAIL prio_ack got %b want 0010", ack_seen); else n_pass++;
    n_checks++; if (int_pending !== 4'b0100) $display("FAIL prio_pending got %b want 0100", int_pending); else n_pass++;
    n_checks++; if (int_active !== 1'b1) $display("FAIL prio_active got %b want 1", int_active); else n_pass++;
    step(0, 0, '0, 1);
    n_checks++; if (pc_out !== 27'h101) $display("FAIL prio_reti got %h want 101", pc_out); else n_pass++;
    n_checks++; if (int_active !== 1'b0) $display("FAIL prio_reti_active got %b want 0", int_active); else n_pass++;
    step(0, 0, '0, 0);
    n_checks++; if (pc_out !== 27'h003) $display("FAIL prio_second_vec got %h want 003", pc_out); else n_pass++;
    n_checks++; if (ack_seen !== 4'b0100) $display("FAIL prio_second_ack got %b want 0100", ack_seen); else n_pass++;
  endtask

  task automatic test_jump_backup();
    do_reset();
    step(1, 0, 27'h200, 0);
    int_in = 4'b1000; tick(); int_in = '0; tick();
    step(1, 1, 27'h010, 0);
    n_checks++; if (pc_out !== 27'h004) $display("FAIL jmpint_vec got %h want 004", pc_out); else n_pass++;
    step(0, 0, '0, 1);
    n_checks++; if (pc_out !== 27'h210) $display("FAIL jmpint_reti got %h want 210", pc_out); else n_pass++;
  endtask

  task automatic test_mask();
    do_reset();
    step(1, 0, 27'h100, 0);
    mask_we = 1; mask_wdata = 4'b1110; tick(); mask_we = 0;
    int_in = 4'b0001; tick(); int_in = '0;
    step(0, 0, '0, 0); step(0, 0, '0, 0);
    n_checks++; if (pc_out !== 27'h102) $display("FAIL mask_blocked_pc got %h want 102", pc_out); else n_pass++;
    n_checks++; if (int_pending !== 4'b0001) $display("FAIL mask_pending got %b want 0001", int_pending); else n_pass++;
    mask_we = 1; mask_wdata = 4'b1111; tick(); mask_we = 0;
    step(0, 0, '0, 0);
    n_checks++; if (pc_out !== 27'h001) $display("FAIL mask_unmasked_pc got %h want 001", pc_out); else n_pass++;
    n_checks++; if (ack_seen !== 4'b0001) $display("FAIL mask_unmasked_ack got %b want 0001", ack_seen); else n_pass++;
  endtask

  task automatic test_set_wins();
    do_reset();
    step(1, 0, 27'h100, 0);
    int_in = 4'b0001; tick(); int_in = '0; tick();
    int_in = 4'b0001;
    step(0, 0, '0, 0);
    int_in = '0;
    n_checks++; if (ack_seen !== 4'b0001) $display("FAIL setwin_ack got %b want 0001", ack_seen); else n_pass++;
    n_checks++; if (int_pending !== 4'b0001) $display("FAIL setwin_pending got %b want 0001", int_pending); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    step(1, 0, 27'h7FFFFFF, 0);
    step(0, 0, '0, 0);
    n_checks++; if (pc_out !== 27'h0000000) $display("FAIL wrap_pc got %h want 0000000", pc_out); else n_pass++;
    step(0, 0, '0, 1);
    n_checks++; if (pc_out !== 27'h0000001) $display("FAIL wrap_stray_reti got %h want 0000001", pc_out); else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    writeBack = 1; repeat (4) tick(); writeBack = 0; tick();
    n_checks++; if (pc_out !== 27'hC01401) $display("FAIL hold_single_step got %h want c01401", pc_out); else n_pass++;
  endtask

  task automatic test_reset_mid_handler();
    do_reset();
    step(1, 0, 27'h100, 0);
    int_in = 4'b0101; tick(); int_in = '0; tick();
    writeBack = 1; tick();
    n_checks++; if (int_ack !== 4'b0001) $display("FAIL midrst_ack_before got %b want 0001", int_ack); else n_pass++;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (pc_out !== 27'hC01400) $display("FAIL midrst_pc got %h want c01400", pc_out); else n_pass++;
    n_checks++; if (int_active !== 1'b0) $display("FAIL midrst_active got %b want 0", int_active); else n_pass++;
    n_checks++; if (int_pending !== 4'b0000) $display("FAIL midrst_pending got %b want 0000", int_pending); else n_pass++;
    n_checks++; if (int_ack !== 4'b0000) $display("FAIL midrst_ack got %b want 0000", int_ack); else n_pass++;
    clear_inputs();
    #3 reset = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_random();
    do_reset();
    step(1, 0, 27'h080, 0);
    for (int k = 0; k < 400; k++) begin
      writeBack  = 1'($urandom_range(0, 1));
      jump       = ($urandom_range(0, 3) == 0);
      offset     = 1'($urandom_range(0, 1));
      jump_addr  = offset ? 27'($urandom_range(0, 64)) : 27'($urandom_range(0, 'h3FF));
      reti       = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) int_in = 4'($urandom);
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = 4'($urandom);
      tick();
      n_checks++; if (pc_out !== m_pc) $display("FAIL rand_pc cyc %0d got %h want %h", k, pc_out, m_pc); else n_pass++;
      n_checks++; if (int_active !== m_act) $display("FAIL rand_active cyc %0d got %b want %b", k, int_active, m_act); else n_pass++;
      n_checks++; if (int_pending !== m_pend) $display("FAIL rand_pending cyc %0d got %b want %b", k, int_pending, m_pend); else n_pass++;
      n_checks++; if (int_ack !== m_ack) $display("FAIL rand_ack cyc %0d got %b want %b", k, int_ack, m_ack); else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_rom_steps();
    test_priority();
    test_jump_backup();
    test_mask();
    test_set_wins();
    test_wrap();
    test_hold();
    test_reset_mid_handler();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_int_ctrl.md
PC_INT_CTRL -- requirements
Module: pc_int_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- WIDTH, 27, program counter width.
- NUM_INT, 8, interrupt channel count (1..16).
- PC_START, 27'hC01400, reset value of pc_out.
- VECTOR_BASE, 0, channel i vector = VECTOR_BASE + i + 1.
- ROM_BASE, 27'hC01400, interrupts are not taken while pc_out >= ROM_BASE.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- writeBack, in, 1, PC step strobe; a step occurs in a cycle where writeBack=1 and its registered previous value=0.
- jump, in, 1, take jump on this step.
- offset, in, 1, jump is relative (pc_out + jump_addr).
- jump_addr, in, WIDTH, jump target or offset.
- reti, in, 1, return from interrupt on this step.
- int_in, in, NUM_INT, level interrupt requests, rising-edge sensitive.
- mask_we, in, 1, write the mask register.
- mask_wdata, in, NUM_INT, new mask (1 = channel enabled).
- pc_out, out, WIDTH, current program counter.
- int_ack, out, NUM_INT, one-hot, one-cycle pulse on the step that enters channel i.
- int_pending, out, NUM_INT, latched pending edges.
- int_active, out, 1, inside a handler (global interrupts disabled).

Function
REQ-003 int_in SHALL be edge-detected against a registered copy; each rising edge sets pending[i] on the next clock, whether or not the mask or int_active allows service.
REQ-004 On a step, the block SHALL act on the first matching condition in this order: (a) reti & int_active, (b) interrupt entry, (c) jump, (d) increment.
REQ-005 Reti: pc_out <= backup; int_active <= 0. reti while int_active=0 SHALL be ignored, and the step falls through to (b)-(d).
REQ-006 Interrupt entry SHALL require all of: int_active=0, pc_out < ROM_BASE, and (pending & mask) != 0.
REQ-007 Interrupt arbitration SHALL be fixed priority, lowest index wins.
REQ-008 On interrupt entry: pc_out <= VECTOR_BASE+i+1; int_active <= 1; pending[i] cleared; int_ack[i] pulses for exactly one cycle; other pending bits are retained.
REQ-009 The backup SHALL capture the address the interrupted step would have produced:
- jump & offset: pc_out + jump_addr.
- jump & ~offset: jump_addr.
- otherwise: pc_out + 1.
REQ-010 Jump: pc_out <= offset ? pc_out + jump_addr : jump_addr.
REQ-011 Increment: pc_out <= pc_out + 1.
REQ-012 All PC arithmetic SHALL be modulo 2^WIDTH; no overflow flag.
REQ-013 In cycles with no step, pc_out, backup and int_active SHALL hold their values.
REQ-014 Latency: pc_out, int_active and int_ack SHALL update on the clock edge that samples the step, i.e. one cycle after writeBack rises.
REQ-015 If a new edge on channel i arrives in the same cycle pending[i] is cleared by service, set SHALL win and pending[i] stays 1.
REQ-016 mask_we SHALL update the mask on the next clock; arbitration in that same cycle uses the old mask.
REQ-017 A masked channel's pending bit SHALL persist and be serviced once it is unmasked.
REQ-018 Single backup register: no nesting; pending edges arriving during a handler wait until after reti.
REQ-019 writeBack held high SHALL produce exactly one step.

Reset
REQ-020 On reset low, asynchronously: pc_out=PC_START; backup=0; int_active=0; pending=0; int_ack=0; mask=all ones; edge registers=0; writeBack previous value=0.
REQ-021 While reset is low, steps and edges SHALL be ignored.
REQ-022 Reset asserted mid-handler SHALL abandon the handler with no residual pending state.
REQ-023 Release SHALL be synchronised to clk; the first step is accepted no earlier than the second rising edge after release.

Verification (WIDTH=27, NUM_INT=4, defaults)
REQ-024 Reset then 3 steps -> pc_out 0xC01400, 0xC01401, 0xC01402, 0xC01403; int edge on ch0 during ROM execution -> not taken, int_pending=0001.
REQ-025 pc_out=0x100; edges on ch2 and ch1 in the same cycle; step -> pc_out=0x002, int_ack=0010, backup=0x101, int_pending=0100; reti step -> pc_out=0x101; next step -> pc_out=0x003, int_ack=0100.
REQ-026 pc_out=0x200; step with jump=1, offset=1, jump_addr=0x10 and ch3 pending -> pc_out=0x004; reti -> pc_out=0x210.
REQ-027 mask=1110; ch0 edge; 2 steps -> no entry, pc_out +2; write mask 1111; step -> pc_out=0x001, int_ack=0001.
REQ-028 pc_out=0x7FFFFFF; step -> pc_out=0x0000000; reti with int_active=0 -> pc_out=0x0000001.
REQ-029 Inside a handler, reset pulse low -> pc_out=0xC01400, int_active=0, int_pending=0000, int_ack=0000 immediately.
